// File: rtl/regfile_sb.sv
// Integer register file with two bypassed combinational read ports, one write port,
// optional hardwired zero register and a per-register busy scoreboard for RAW stalls.
module regfile_sb #(
   parameter int XLEN     = 32,
   parameter int AW       = 5,
   parameter int ZERO_REG = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   ra1,
   input  logic [AW-1:0]   ra2,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2,
   input  logic            we,
   input  logic [AW-1:0]   wa,
   input  logic [XLEN-1:0] wd,
   input  logic            rsv_en,
   input  logic [AW-1:0]   rsv_addr,
   output logic            busy1,
   output logic            busy2,
   output logic            any_busy
);

   localparam int NREG = 1 << AW;
   localparam bit ZR   = (ZERO_REG != 0);

   logic [XLEN-1:0] mem_q [NREG];
   logic [NREG-1:0] busy_q, busy_d;
   logic            commit;
   logic            rsv_ok;

   assign commit = we && !rst && !(ZR && (wa == '0));
   assign rsv_ok = rsv_en && !(ZR && (rsv_addr == '0));

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
      end else if (commit) begin
         mem_q[wa] <= wd;
      end
   end

   // A new reservation on the retiring register wins: it belongs to a younger instruction.
   always_comb begin
      busy_d = busy_q;
      if (commit) busy_d[wa] = 1'b0;
      if (rsv_ok) busy_d[rsv_addr] = 1'b1;
      if (rst)    busy_d = '0;
   end

   always_ff @(posedge clk) begin
      busy_q <= busy_d;
   end

   always_comb begin
      rd1   = mem_q[ra1];
      busy1 = busy_q[ra1];
      if (commit && (wa == ra1)) begin
         rd1   = wd;
         busy1 = 1'b0;
      end
      if (ZR && (ra1 == '0)) begin
         rd1   = '0;
         busy1 = 1'b0;
      end
   end

   always_comb begin
      rd2   = mem_q[ra2];
      busy2 = busy_q[ra2];
      if (commit && (wa == ra2)) begin
         rd2   = wd;
         busy2 = 1'b0;
      end
      if (ZR && (ra2 == '0)) begin
         rd2   = '0;
         busy2 = 1'b0;
      end
   end

   assign any_busy = |busy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: per-cycle vector table on the default configuration,
// plus a short sequence on a 64-bit, 16-entry, no-zero-register instance.
module tb_regfile_sb;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // default instance (XLEN=32, AW=5, ZERO_REG=1)
   logic        rst, we, rsv_en;
   logic [4:0]  ra1, ra2, wa, rsv_addr;
   logic [31:0] wd, rd1, rd2;
   logic        busy1, busy2, any_busy;

   regfile_sb u_dut (
      .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
      .we(we), .wa(wa), .wd(wd), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
      .busy1(busy1), .busy2(busy2), .any_busy(any_busy)
   );

   // wide instance
   logic        b_rst, b_we, b_rsv_en;
   logic [3:0]  b_ra1, b_ra2, b_wa, b_rsv_addr;
   logic [63:0] b_wd, b_rd1, b_rd2;
   logic        b_busy1, b_busy2, b_any_busy;

   regfile_sb #(.XLEN(64), .AW(4), .ZERO_REG(0)) u_dut64 (
      .clk(clk), .rst(b_rst), .ra1(b_ra1), .ra2(b_ra2), .rd1(b_rd1), .rd2(b_rd2),
      .we(b_we), .wa(b_wa), .wd(b_wd), .rsv_en(b_rsv_en), .rsv_addr(b_rsv_addr),
      .busy1(b_busy1), .busy2(b_busy2), .any_busy(b_any_busy)
   );

   typedef struct {
      bit          rst;
      bit          we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [4:0]  ra1;
      logic [4:0]  ra2;
      bit          rsv;
      logic [4:0]  rsv_addr;
      logic [31:0] e_rd1;
      logic [31:0] e_rd2;
      logic [2:0]  e_busy;   // {busy1, busy2, any_busy}
   } vec_t;

   vec_t vecs[$];
   int tests = 0;
   int failed = 0;

   function automatic vec_t mk(bit r, bit w, logic [4:0] a, logic [31:0] d,
                               logic [4:0] r1, logic [4:0] r2, bit rv, logic [4:0] rva,
                               logic [31:0] e1, logic [31:0] e2, logic [2:0] eb);
      vec_t v;
      v.rst = r; v.we = w; v.wa = a; v.wd = d; v.ra1 = r1; v.ra2 = r2;
      v.rsv = rv; v.rsv_addr = rva; v.e_rd1 = e1; v.e_rd2 = e2; v.e_busy = eb;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   initial begin
      rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0; rsv_en = 1'b0; rsv_addr = '0;
      b_rst = 1'b1; b_we = 1'b0; b_wa = '0; b_wd = '0; b_ra1 = '0; b_ra2 = '0;
      b_rsv_en = 1'b0; b_rsv_addr = '0;
      repeat (2) @(posedge clk);

      //            rst we wa  wd            ra1 ra2 rsv ra  exp_rd1       exp_rd2       {b1,b2,any}
      // reset holds: bypass disabled, array reads zero
      vecs.push_back(mk(1, 1, 3, 32'h1111_1111, 3, 31, 0, 0, 32'h0,         32'h0,         3'b000));
      // fill with A5 pattern, write to r0 ignored
      vecs.push_back(mk(0, 1, 1, 32'hA5A5_A5A5, 1, 0,  0, 0, 32'hA5A5_A5A5, 32'h0,         3'b000));
      vecs.push_back(mk(0, 1, 2, 32'hA5A5_A5A5, 1, 2,  0, 0, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 3'b000));
      vecs.push_back(mk(0, 1, 0, 32'hFFFF_FFFF, 0, 2,  0, 0, 32'h0,         32'hA5A5_A5A5, 3'b000));
      // rst cycle: array contents visible, write to r5 lost
      vecs.push_back(mk(1, 1, 5, 32'h0000_0001, 1, 5,  0, 0, 32'hA5A5_A5A5, 32'h0,         3'b000));
      vecs.push_back(mk(0, 0, 0, 32'h0,         1, 2,  0, 0, 32'h0,         32'h0,         3'b000));
      vecs.push_back(mk(0, 0, 0, 32'h0,         5, 0,  0, 0, 32'h0,         32'h0,         3'b000));
      // write-through bypass then array read
      vecs.push_back(mk(0, 1, 7, 32'h1234_5678, 7, 8,  0, 0, 32'h1234_5678, 32'h0,         3'b000));
      vecs.push_back(mk(0, 0, 0, 32'h0,         7, 8,  0, 0, 32'h1234_5678, 32'h0,         3'b000));
      // scoreboard lifecycle on r5
      vecs.push_back(mk(0, 0, 0, 32'h0,         5, 7,  1, 5, 32'h0,         32'h1234_5678, 3'b000));
      vecs.push_back(mk(0, 0, 0, 32'h0,         5, 5,  0, 0, 32'h0,         32'h0,         3'b111));
      vecs.push_back(mk(0, 1, 5, 32'h0000_0055, 5, 7,  0, 0, 32'h0000_0055, 32'h1234_5678, 3'b001));
      vecs.push_back(mk(0, 0, 0, 32'h0,         5, 5,  0, 0, 32'h0000_0055, 32'h0000_0055, 3'b000));
      // simultaneous reserve and retire on r3: set wins
      vecs.push_back(mk(0, 1, 3, 32'h0000_0033, 3, 4,  1, 3, 32'h0000_0033, 32'h0,         3'b000));
      vecs.push_back(mk(0, 0, 0, 32'h0,         3, 3,  0, 0, 32'h0000_0033, 32'h0000_0033, 3'b111));
      vecs.push_back(mk(0, 1, 3, 32'h0000_0034, 3, 2,  0, 0, 32'h0000_0034, 32'h0,         3'b001));
      vecs.push_back(mk(0, 0, 0, 32'h0,         3, 7,  0, 0, 32'h0000_0034, 32'h1234_5678, 3'b000));
      // reservation of r0 is ignored
      vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0,  1, 0, 32'h0,         32'h0,         3'b000));
      vecs.push_back(mk(0, 0, 0, 32'h0,         0, 3,  0, 0, 32'h0,         32'h0000_0034, 3'b000));
      // reserve 2, 4, 9 then reset with a concurrent write to r2
      vecs.push_back(mk(0, 0, 0, 32'h0,         2, 4,  1, 2, 32'h0,         32'h0,         3'b000));
      vecs.push_back(mk(0, 0, 0, 32'h0,         2, 4,  1, 4, 32'h0,         32'h0,         3'b101));
      vecs.push_back(mk(0, 0, 0, 32'h0,         4, 2,  1, 9, 32'h0,         32'h0,         3'b111));
      vecs.push_back(mk(1, 1, 2, 32'h0000_0099, 9, 2,  0, 0, 32'h0,         32'h0,         3'b111));
      vecs.push_back(mk(0, 0, 0, 32'h0,         2, 9,  0, 0, 32'h0,         32'h0,         3'b000));
      vecs.push_back(mk(0, 0, 0, 32'h0,         5, 7,  0, 0, 32'h0,         32'h0,         3'b000));

      foreach (vecs[i]) begin
         @(negedge clk);
         b_rst    = 1'b0;
         rst      = vecs[i].rst;
         we       = vecs[i].we;
         wa       = vecs[i].wa;
         wd       = vecs[i].wd;
         ra1      = vecs[i].ra1;
         ra2      = vecs[i].ra2;
         rsv_en   = vecs[i].rsv;
         rsv_addr = vecs[i].rsv_addr;
         #1;
         chk($sformatf("v%0d rd1", i), 64'(rd1), 64'(vecs[i].e_rd1));
         chk($sformatf("v%0d rd2", i), 64'(rd2), 64'(vecs[i].e_rd2));
         chk($sformatf("v%0d busy", i), 64'({busy1, busy2, any_busy}), 64'(vecs[i].e_busy));
      end
      @(negedge clk);
      rst = 1'b0; we = 1'b0; rsv_en = 1'b0;

      // wide instance: r0 is an ordinary register
      b_we = 1'b1; b_wa = 4'd0; b_wd = 64'hDEAD_BEEF_CAFE_F00D; b_ra1 = 4'd0; b_ra2 = 4'd15;
      #1;
      chk("w64 r0 bypass", b_rd1, 64'hDEAD_BEEF_CAFE_F00D);
      chk("w64 r15 reset", b_rd2, 64'h0);
      @(negedge clk);
      b_wa = 4'd15; b_wd = 64'h0123_4567_89AB_CDEF;
      #1;
      chk("w64 r0 array", b_rd1, 64'hDEAD_BEEF_CAFE_F00D);
      chk("w64 r15 bypass", b_rd2, 64'h0123_4567_89AB_CDEF);
      @(negedge clk);
      b_we = 1'b0; b_rsv_en = 1'b1; b_rsv_addr = 4'd0;
      #1;
      chk("w64 r15 array", b_rd2, 64'h0123_4567_89AB_CDEF);
      chk("w64 busy pre", 64'({b_busy1, b_busy2, b_any_busy}), 64'd0);
      @(negedge clk);
      b_rsv_en = 1'b0;
      #1;
      chk("w64 r0 busy", 64'({b_busy1, b_busy2, b_any_busy}), 64'b101);
      chk("w64 r0 hold", b_rd1, 64'hDEAD_BEEF_CAFE_F00D);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
